// File: rtl/fetch_if_id_stage.sv
// Instruction-fetch stage and IF/ID pipeline register for the RV32I pipeline.
// Issues in-order imem requests, buffers responses, and feeds decode.
module fetch_if_id_stage #(
  parameter int unsigned            ADDR_WIDTH      = 32,
  parameter int unsigned            INST_WIDTH      = 32,
  parameter logic [ADDR_WIDTH-1:0]  RESET_PC        = 32'h0000_0000,
  parameter int unsigned            MAX_OUTSTANDING = 2,
  parameter int unsigned            FIFO_DEPTH      = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  Stall_D,
  input  logic                  Flush_D,
  input  logic                  PCSrc_E,
  input  logic [ADDR_WIDTH-1:0] PCTarget_E,
  output logic                  imem_req_valid,
  input  logic                  imem_req_ready,
  output logic [ADDR_WIDTH-1:0] imem_req_addr,
  input  logic                  imem_rsp_valid,
  input  logic [INST_WIDTH-1:0] imem_rsp_data,
  output logic [INST_WIDTH-1:0] Instruction_D,
  output logic [ADDR_WIDTH-1:0] PC_D,
  output logic [ADDR_WIDTH-1:0] PCPlus4_D,
  output logic                  Valid_D
);

  localparam int unsigned CW = $clog2(MAX_OUTSTANDING + FIFO_DEPTH + 1);
  localparam int unsigned PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [INST_WIDTH-1:0] NOP  = INST_WIDTH'(32'h0000_0013);
  localparam logic [ADDR_WIDTH-1:0] FOUR = ADDR_WIDTH'(4);

  logic [ADDR_WIDTH-1:0] pc_f;
  logic [ADDR_WIDTH-1:0] rsp_pc;
  logic [CW-1:0]         outstanding;
  logic [CW-1:0]         drop_count;
  logic [CW-1:0]         fifo_count;
  logic [PW-1:0]         rd_ptr;
  logic [PW-1:0]         wr_ptr;
  logic [ADDR_WIDTH-1:0] fifo_pc   [FIFO_DEPTH];
  logic [INST_WIDTH-1:0] fifo_inst [FIFO_DEPTH];

  logic credit_ok;
  logic accept;
  logic push;
  logic pop;
  logic fifo_nonempty;

  function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
    return (p == PW'(FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_comb begin
    fifo_nonempty  = (fifo_count != '0);
    credit_ok      = ((outstanding + fifo_count) < CW'(FIFO_DEPTH)) &&
                     (outstanding < CW'(MAX_OUTSTANDING));
    imem_req_valid = !rst && !PCSrc_E && credit_ok;
    accept         = imem_req_valid && imem_req_ready;
    push           = imem_rsp_valid && (drop_count == '0) && !PCSrc_E;
    pop            = !PCSrc_E && !Flush_D && !Stall_D && fifo_nonempty;
  end

  assign imem_req_addr = pc_f;

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_f        <= RESET_PC;
      rsp_pc      <= RESET_PC;
      outstanding <= '0;
      drop_count  <= '0;
      fifo_count  <= '0;
      rd_ptr      <= '0;
      wr_ptr      <= '0;
    end else begin
      outstanding <= outstanding + CW'(accept) - CW'(imem_rsp_valid);
      if (PCSrc_E) begin
        pc_f       <= PCTarget_E;
        rsp_pc     <= PCTarget_E;
        fifo_count <= '0;
        rd_ptr     <= '0;
        wr_ptr     <= '0;
        // Every request still in flight after a redirect is stale; this equals
        // drop_count + outstanding - rsp when nothing was already marked for dropping.
        drop_count <= outstanding - CW'(imem_rsp_valid);
      end else begin
        if (accept)
          pc_f <= pc_f + FOUR;
        if (imem_rsp_valid && (drop_count != '0))
          drop_count <= drop_count - 1'b1;
        if (push) begin
          wr_ptr <= ptr_next(wr_ptr);
          rsp_pc <= rsp_pc + FOUR;
        end
        if (pop)
          rd_ptr <= ptr_next(rd_ptr);
        fifo_count <= fifo_count + CW'(push) - CW'(pop);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && push) begin
      fifo_pc[wr_ptr]   <= rsp_pc;
      fifo_inst[wr_ptr] <= imem_rsp_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      Instruction_D <= NOP;
      PC_D          <= '0;
      PCPlus4_D     <= '0;
      Valid_D       <= 1'b0;
    end else if (PCSrc_E || Flush_D) begin
      Instruction_D <= NOP;
      Valid_D       <= 1'b0;
    end else if (Stall_D) begin
      Instruction_D <= Instruction_D;
      Valid_D       <= Valid_D;
    end else if (fifo_nonempty) begin
      Instruction_D <= fifo_inst[rd_ptr];
      PC_D          <= fifo_pc[rd_ptr];
      PCPlus4_D     <= fifo_pc[rd_ptr] + FOUR;
      Valid_D       <= 1'b1;
    end else begin
      Instruction_D <= NOP;
      Valid_D       <= 1'b0;
    end
  end

endmodule

// File: tb/tb_fetch_if_id_stage.sv
// Randomized self-checking bench for fetch_if_id_stage with an in-order
// variable-latency imem model and an expected-PC-stream reference.
module tb_fetch_if_id_stage;

  localparam int unsigned  AW   = 32;
  localparam int unsigned  IW   = 32;
  localparam logic [31:0]  RPC  = 32'h0000_0000;
  localparam logic [31:0]  NOP  = 32'h0000_0013;
  localparam int unsigned  MAXO = 2;

  logic          clk;
  logic          rst;
  logic          Stall_D;
  logic          Flush_D;
  logic          PCSrc_E;
  logic [AW-1:0] PCTarget_E;
  logic          imem_req_valid;
  logic          imem_req_ready;
  logic [AW-1:0] imem_req_addr;
  logic          imem_rsp_valid;
  logic [IW-1:0] imem_rsp_data;
  logic [IW-1:0] Instruction_D;
  logic [AW-1:0] PC_D;
  logic [AW-1:0] PCPlus4_D;
  logic          Valid_D;

  fetch_if_id_stage #(
    .ADDR_WIDTH      (AW),
    .INST_WIDTH      (IW),
    .RESET_PC        (RPC),
    .MAX_OUTSTANDING (MAXO),
    .FIFO_DEPTH      (2)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .Stall_D        (Stall_D),
    .Flush_D        (Flush_D),
    .PCSrc_E        (PCSrc_E),
    .PCTarget_E     (PCTarget_E),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .Instruction_D  (Instruction_D),
    .PC_D           (PC_D),
    .PCPlus4_D      (PCPlus4_D),
    .Valid_D        (Valid_D)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    int          due;
  } req_t;

  req_t        memq[$];
  int          last_due;
  int          n_checks;
  int          n_fail;
  int          cyc;
  int          nvalid;
  int          first_acc;
  int          first_valid;
  int          ready_pct;
  int          lat_min;
  int          lat_max;
  logic [31:0] exp_pc;
  logic        d_rst, d_stall, d_flush, d_pcsrc;
  logic [31:0] d_target;
  logic        p_rst, p_stall, p_flush, p_pcsrc;
  logic [31:0] hold_inst, hold_pc, hold_p4;
  logic        hold_valid;
  logic        last_v, last_r;
  logic [31:0] last_addr;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  function automatic logic [31:0] word(input logic [31:0] a);
    return a * 32'h0001_0001 + 32'h0050_0093;
  endfunction

  // One clock: check what the previous edge produced, then drive the next inputs.
  task automatic step();
    int lat;
    int due;
    @(negedge clk);
    cyc++;
    if (p_rst) begin
      check("rst_valid", 32'(Valid_D), 0);
      check("rst_inst", Instruction_D, NOP);
      check("rst_pc", PC_D, 0);
      check("rst_pc4", PCPlus4_D, 0);
    end else if (p_pcsrc || p_flush) begin
      check("bubble_valid", 32'(Valid_D), 0);
      check("bubble_inst", Instruction_D, NOP);
      check("bubble_pc_kept", PC_D, hold_pc);
    end else if (p_stall) begin
      check("stall_inst", Instruction_D, hold_inst);
      check("stall_pc", PC_D, hold_pc);
      check("stall_pc4", PCPlus4_D, hold_p4);
      check("stall_valid", 32'(Valid_D), 32'(hold_valid));
    end else if (Valid_D) begin
      check("seq_pc", PC_D, exp_pc);
      check("seq_inst", Instruction_D, word(exp_pc));
      check("seq_pc4", PCPlus4_D, PC_D + 32'd4);
      if (first_valid < 0) first_valid = cyc;
      exp_pc = exp_pc + 32'd4;
      nvalid++;
    end else begin
      check("idle_inst", Instruction_D, NOP);
    end
    hold_inst  = Instruction_D;
    hold_pc    = PC_D;
    hold_p4    = PCPlus4_D;
    hold_valid = Valid_D;

    rst        = d_rst;
    Stall_D    = d_stall;
    Flush_D    = d_flush;
    PCSrc_E    = d_pcsrc;
    PCTarget_E = d_target;
    if (d_rst) begin
      memq.delete();
      imem_rsp_valid = 1'b0;
      last_due       = 0;
      exp_pc         = RPC;
      first_acc      = -1;
      first_valid    = -1;
    end else if (memq.size() > 0 && memq[0].due <= cyc) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = word(memq[0].addr);
      void'(memq.pop_front());
    end else begin
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = $urandom;
    end
    if (d_pcsrc && !d_rst) exp_pc = d_target;
    imem_req_ready = ($urandom_range(99) < ready_pct);
    #1;
    if (d_rst || d_pcsrc) begin
      check("req_blocked", 32'(imem_req_valid), 0);
    end else if (last_v && !last_r) begin
      check("req_valid_stable", 32'(imem_req_valid), 1);
      check("req_addr_stable", imem_req_addr, last_addr);
    end
    if (p_rst && !d_rst) check("addr_after_rst", imem_req_addr, RPC);
    if (imem_req_valid && imem_req_ready) begin
      lat = $urandom_range(lat_max, lat_min);
      due = cyc + lat;
      if (due <= last_due) due = last_due + 1;
      last_due = due;
      memq.push_back('{imem_req_addr, due});
      if (first_acc < 0) first_acc = cyc;
      check("outstanding_limit", 32'(memq.size() <= MAXO), 1);
    end
    last_v    = imem_req_valid;
    last_r    = imem_req_ready;
    last_addr = imem_req_addr;
    p_rst     = d_rst;
    p_stall   = d_stall;
    p_flush   = d_flush;
    p_pcsrc   = d_pcsrc;
  endtask

  task automatic expect_next_valid_pc(input string tag, input logic [31:0] pc);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 30 && !seen; i++) begin
      step();
      if (Valid_D) begin
        check(tag, PC_D, pc);
        seen = 1'b1;
      end
    end
    if (!seen) check({tag, "_timeout"}, 0, 1);
  endtask

  initial begin
    logic [31:0] t;
    bit          hit;
    n_checks = 0; n_fail = 0; cyc = 0; nvalid = 0;
    first_acc = -1; first_valid = -1; last_due = 0;
    ready_pct = 100; lat_min = 1; lat_max = 1;
    exp_pc = RPC;
    rst = 1'b1; Stall_D = 1'b0; Flush_D = 1'b0; PCSrc_E = 1'b0; PCTarget_E = '0;
    imem_req_ready = 1'b0; imem_rsp_valid = 1'b0; imem_rsp_data = '0;
    d_rst = 1'b1; d_stall = 1'b0; d_flush = 1'b0; d_pcsrc = 1'b0; d_target = '0;
    p_rst = 1'b1; p_stall = 1'b0; p_flush = 1'b0; p_pcsrc = 1'b0;
    hold_inst = NOP; hold_pc = '0; hold_p4 = '0; hold_valid = 1'b0;
    last_v = 1'b0; last_r = 1'b0; last_addr = '0;

    repeat (2) step();
    d_rst = 1'b0;
    repeat (12) step();
    check("first_fetch_latency", 32'(first_valid - first_acc), 3);

    d_stall = 1'b1;
    repeat (4) step();
    check("stall_backpressure", 32'(imem_req_valid), 0);
    d_stall = 1'b0;
    repeat (10) step();

    lat_min = 2; lat_max = 3;
    hit = 1'b0;
    for (int i = 0; i < 30 && !hit; i++) begin
      step();
      if (memq.size() == 2) hit = 1'b1;
    end
    check("two_outstanding_reached", 32'(hit), 1);
    d_pcsrc = 1'b1; d_target = 32'h100;
    step();
    d_pcsrc = 1'b0;
    expect_next_valid_pc("redirect_pc", 32'h100);
    repeat (6) step();

    lat_min = 1; lat_max = 2;
    hit = 1'b0;
    for (int i = 0; i < 30 && !hit; i++) begin
      if (memq.size() > 0 && memq[0].due <= cyc + 1) hit = 1'b1;
      else step();
    end
    check("rsp_for_stall_redirect", 32'(hit), 1);
    d_pcsrc = 1'b1; d_stall = 1'b1; d_target = 32'h200;
    step();
    d_pcsrc = 1'b0; d_stall = 1'b0;
    expect_next_valid_pc("stall_redirect_pc", 32'h200);

    ready_pct = 50; lat_min = 1; lat_max = 3;
    for (int i = 0; i < 800; i++) begin
      d_stall = ($urandom_range(99) < 20);
      d_flush = ($urandom_range(99) < 5);
      d_pcsrc = ($urandom_range(99) < 4);
      t = 32'($urandom_range(4095));
      if ($urandom_range(7) != 0) t[1:0] = 2'b00;
      if ($urandom_range(15) == 0) t = 32'hFFFF_FFF8;
      d_target = t;
      step();
    end
    d_stall = 1'b0; d_flush = 1'b0; d_pcsrc = 1'b0;

    ready_pct = 100; lat_min = 1; lat_max = 1;
    repeat (6) step();
    d_rst = 1'b1;
    step();
    d_rst = 1'b0;
    repeat (15) step();
    check("progress", 32'(nvalid >= 100), 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
